// File: rtl/seg7_display_if.sv
// Bus bundle between a host and the multi-digit seven-segment display controller.
// The host drives the load/value/control inputs and reads back status and segment outputs.
interface seg7_display_if #(
    parameter int NUM_DIGITS = 6,
    parameter int BIN_WIDTH  = 20
);
    logic                    load;
    logic [BIN_WIDTH-1:0]    value;
    logic                    mode;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic                    busy;
    logic                    overflow;
    logic [NUM_DIGITS*8-1:0] hex_out;

    modport master (
        output load, value, mode, blank_lz, dp_in, blink_en,
        input  busy, overflow, hex_out
    );

    modport slave (
        input  load, value, mode, blank_lz, dp_in, blink_en,
        output busy, overflow, hex_out
    );
endinterface

// File: rtl/seg7_display_ctrl.sv
// Multi-digit seven-segment controller: hex or decimal (sequential double-dabble) rendering
// with overflow dashes, leading-zero blanking, decimal points and per-digit blinking.
module seg7_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BIN_WIDTH  = 20,
    parameter int BLINK_DIV  = 25000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic            clk,
    input  logic            reset,
    seg7_display_if.slave   bus
);
    localparam int DW  = 4 * NUM_DIGITS;
    localparam int CW  = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [NUM_DIGITS*8-1:0] HEX_BLANK = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    state_t                  state, state_next;
    logic [BIN_WIDTH-1:0]    shift_q, shift_next;
    logic [DW-1:0]           bcd_q, bcd_next;
    logic [DW-1:0]           digits_q, digits_next;
    logic [CW-1:0]           iter_q, iter_next;
    logic                    ovf_q, ovf_next;
    logic [DW-1:0]           bcd_adj, bcd_step;
    logic                    bcd_carry;
    logic [39:0]             value_ext;
    logic [BCW-1:0]          blink_cnt;
    logic                    blink_phase;
    logic [NUM_DIGITS*8-1:0] hex_q, hex_next;
    logic [3:0]              cur_digit;
    logic [6:0]              cur_seg;
    logic [7:0]              cur_cell;
    logic                    zero_run;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    assign value_ext = 40'(bus.value);

    // One double-dabble step: +3 on every BCD digit >= 5, then shift in the value MSB.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
        {bcd_carry, bcd_step} = {bcd_adj, shift_q[BIN_WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            digits_q <= '0;
            iter_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_next;
            shift_q  <= shift_next;
            bcd_q    <= bcd_next;
            digits_q <= digits_next;
            iter_q   <= iter_next;
            ovf_q    <= ovf_next;
        end
    end

    always_comb begin
        state_next  = state;
        shift_next  = shift_q;
        bcd_next    = bcd_q;
        digits_next = digits_q;
        iter_next   = iter_q;
        ovf_next    = ovf_q;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    if (!bus.mode) begin
                        digits_next = value_ext[DW-1:0];
                        ovf_next    = |(value_ext >> DW);
                    end else begin
                        shift_next = bus.value;
                        bcd_next   = '0;
                        ovf_next   = 1'b0;
                        iter_next  = '0;
                        state_next = CONVERT;
                    end
                end
            end
            CONVERT: begin
                shift_next = shift_q << 1;
                bcd_next   = bcd_step;
                iter_next  = iter_q + 1'b1;
                if (bcd_carry) begin
                    ovf_next = 1'b1;
                end
                if (iter_q == CW'(BIN_WIDTH - 1)) begin
                    digits_next = bcd_step;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Free-running blink timebase; load never disturbs it so blinking stays even.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Walk from the top digit down; zero_run stays set while every digit so far is zero.
    always_comb begin
        hex_next  = '0;
        cur_digit = '0;
        cur_seg   = '0;
        cur_cell  = '0;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            cur_digit = digits_q[4*k +: 4];
            zero_run  = zero_run & (cur_digit == 4'd0);
            if (blink_phase && bus.blink_en[k]) begin
                cur_cell = 8'hFF;
            end else begin
                if (ovf_q) begin
                    cur_seg = 7'h3F;
                end else if (bus.blank_lz && zero_run && (k != 0)) begin
                    cur_seg = 7'h7F;
                end else begin
                    cur_seg = glyph(cur_digit);
                end
                cur_cell = {~bus.dp_in[k], cur_seg};
            end
            hex_next[8*k +: 8] = (ACTIVE_LOW != 0) ? cur_cell : ~cur_cell;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q <= HEX_BLANK;
        end else begin
            hex_q <= hex_next;
        end
    end

    assign bus.busy     = (state == CONVERT);
    assign bus.overflow = ovf_q;
    assign bus.hex_out  = hex_q;
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl: vector table with a scoreboard queue,
// plus hand-written sequences for live controls, busy-time loads, reset abort and blinking.
module tb_seg7_display_ctrl;
    localparam int ND = 6;
    localparam int BW = 20;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seg7_display_if #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) bus();

    seg7_display_ctrl #(
        .NUM_DIGITS(ND),
        .BIN_WIDTH (BW),
        .BLINK_DIV (4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [BW-1:0]   value;
        logic            mode;
        logic            blank_lz;
        logic [ND-1:0]   dp_in;
        logic [8*ND-1:0] exp_hex;
        logic            exp_ovf;
    } vec_t;

    typedef struct {
        string           name;
        logic [8*ND-1:0] hex;
        logic            ovf;
        int              busy_cycles;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[12];
    int   n_vectors     = 0;
    int   n_miscompares = 0;
    int   busy_cycles;

    function automatic logic [6:0] ref_glyph(input int d);
        case (d)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
           12: return 7'h46;  13: return 7'h21;  14: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Reference display: decimal digits via division, leading zeros via highest non-zero index.
    function automatic logic [8*ND-1:0] model_hex(input logic [BW-1:0] v, input logic dec,
                                                  input logic blz, input logic [ND-1:0] dp,
                                                  output logic ovf);
        longint          val = longint'(v);
        longint          p   = 1;
        int              d[ND];
        int              msnz = 0;
        logic [6:0]      seg;
        logic [8*ND-1:0] r = '0;
        if (dec) begin
            ovf = (val >= 64'd1000000);
            for (int k = 0; k < ND; k++) begin
                d[k] = int'((val / p) % 10);
                p    = p * 10;
            end
        end else begin
            ovf = ((val >> (4*ND)) != 0);
            for (int k = 0; k < ND; k++) d[k] = int'((val >> (4*k)) & 15);
        end
        for (int k = 0; k < ND; k++) if (d[k] != 0) msnz = k;
        for (int k = 0; k < ND; k++) begin
            if (ovf)                  seg = 7'h3F;
            else if (blz && k > msnz) seg = 7'h7F;
            else                      seg = ref_glyph(d[k]);
            r[8*k +: 8] = {~dp[k], seg};
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wait_idle();
        busy_cycles = 0;
        while (bus.busy === 1'b1 && busy_cycles < 200) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic check_scoreboard();
        exp_t e;
        if (sb_q.size() == 0) begin
            checkOutput("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            checkOutput({e.name, "/hex"}, 64'(bus.hex_out), 64'(e.hex));
            checkOutput({e.name, "/ovf"}, 64'(bus.overflow), 64'(e.ovf));
            checkOutput({e.name, "/busy"}, 64'(busy_cycles), 64'(e.busy_cycles));
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        bus.value    = v.value;
        bus.mode     = v.mode;
        bus.blank_lz = v.blank_lz;
        bus.dp_in    = v.dp_in;
        bus.load     = 1'b1;
        e.name        = name;
        e.hex         = v.exp_hex;
        e.ovf         = v.exp_ovf;
        e.busy_cycles = v.mode ? BW : 0;
        sb_q.push_back(e);
        @(negedge clk);
        bus.load = 1'b0;
        wait_idle();
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        logic [7:0] exp_d0;

        reset        = 1'b1;
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.mode     = 1'b0;
        bus.blank_lz = 1'b0;
        bus.dp_in    = '0;
        bus.blink_en = '0;

        vecs[0] = '{20'd123456,  1'b1, 1'b0, 6'b000000, 48'hF9A4B0999282, 1'b0};
        vecs[1] = '{20'd42,      1'b1, 1'b1, 6'b000001, 48'hFFFFFFFF9924, 1'b0};
        vecs[2] = '{20'd1000000, 1'b1, 1'b0, 6'b000000, 48'hBFBFBFBFBFBF, 1'b1};
        vecs[3] = '{20'd999999,  1'b1, 1'b0, 6'b000000, 48'h909090909090, 1'b0};
        vecs[4] = '{20'hABCDE,   1'b0, 1'b0, 6'b000000, 48'hC08883C6A186, 1'b0};
        vecs[5] = '{20'd0,       1'b1, 1'b1, 6'b000000, 48'hFFFFFFFFFFC0, 1'b0};
        vecs[6] = '{20'hFFFFF,   1'b0, 1'b1, 6'b100000, 48'h7F8E8E8E8E8E, 1'b0};
        vecs[7] = '{20'hFFFFF,   1'b1, 1'b0, 6'b000000, 48'hBFBFBFBFBFBF, 1'b1};
        vecs[8]  = '{20'd654321, 1'b1, 1'b0, 6'b101010, '0, 1'b0};
        vecs[9]  = '{20'h00100,  1'b0, 1'b1, 6'b000000, '0, 1'b0};
        vecs[10] = '{20'd1,      1'b1, 1'b1, 6'b111111, '0, 1'b0};
        vecs[11] = '{20'd100000, 1'b1, 1'b1, 6'b000000, '0, 1'b0};
        for (int i = 8; i < 12; i++) begin
            vecs[i].exp_hex = model_hex(vecs[i].value, vecs[i].mode, vecs[i].blank_lz,
                                        vecs[i].dp_in, vecs[i].exp_ovf);
        end

        repeat (3) @(negedge clk);
        checkOutput("reset/hex", 64'(bus.hex_out), 64'(48'hFFFFFFFFFFFF));
        checkOutput("reset/busy", 64'(bus.busy), 64'd0);
        checkOutput("reset/ovf", 64'(bus.overflow), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
            check_scoreboard();
        end

        // blank_lz is a live control: dropping it shows the zeros one cycle later
        applyStimulus(vecs[1], "lz_reload");
        check_scoreboard();
        bus.blank_lz = 1'b0;
        @(negedge clk);
        checkOutput("lz_live_off", 64'(bus.hex_out), 64'(48'hC0C0C0C09924));

        // Load pulsed mid-conversion must neither restart nor queue
        bus.dp_in    = '0;
        bus.value    = 20'd123456;
        bus.mode     = 1'b1;
        bus.load     = 1'b1;
        e.name        = "busy_ignore";
        e.hex         = 48'hF9A4B0999282;
        e.ovf         = 1'b0;
        e.busy_cycles = BW;
        sb_q.push_back(e);
        @(negedge clk);
        bus.load    = 1'b0;
        busy_cycles = 0;
        for (int c = 1; c < 200; c++) begin
            if (bus.busy !== 1'b1) break;
            busy_cycles++;
            if (c == 5) begin
                bus.value = 20'd7;
                bus.mode  = 1'b0;
                bus.load  = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
        repeat (3) @(negedge clk);
        check_scoreboard();

        // Reset during a conversion aborts it and restores every reset value
        bus.value = 20'd123456;
        bus.mode  = 1'b1;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_abort/busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_abort/hex", 64'(bus.hex_out), 64'(48'hFFFFFFFFFFFF));
        checkOutput("rst_abort/ovf", 64'(bus.overflow), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_abort/zeros", 64'(bus.hex_out), 64'(48'hC0C0C0C0C0C0));
        applyStimulus(vecs[4], "after_reset_hex");
        check_scoreboard();

        // Blink with a 4-cycle half period, phase aligned to a fresh reset
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        bus.value    = 20'h5;
        bus.mode     = 1'b0;
        bus.blank_lz = 1'b0;
        bus.dp_in    = 6'b000001;
        bus.blink_en = 6'b000001;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        for (int j = 2; j <= 17; j++) begin
            @(negedge clk);
            exp_d0 = (((j - 1) / 4) % 2 == 1) ? 8'hFF : 8'h12;
            checkOutput($sformatf("blink_d0_c%0d", j), 64'(bus.hex_out[7:0]), 64'(exp_d0));
            checkOutput($sformatf("blink_rest_c%0d", j), 64'(bus.hex_out[8*ND-1:8]),
                        64'(40'hC0C0C0C0C0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
